// File: rtl/apb_slave_bridge.sv
// APB4 slave to register-block bridge: one req/ack transaction per APB transfer, wait states until ack.
// Optional reg_ack timeout is built in when APB_SLV_TIMEOUT_EN is defined.
module apb_slave_bridge #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int ADDR_LIMIT  = 'h400,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_W-1:0]     prdata,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic [DATA_W/8-1:0]   reg_be,
    input  logic                  reg_ack,
    input  logic [DATA_W-1:0]     reg_rdata,
    input  logic                  reg_err
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W + 1)'(ADDR_LIMIT);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic setup, dec_err, in_req, timeout;

    assign setup   = psel & ~penable;
    assign dec_err = ({1'b0, paddr} >= LIMIT) || ((paddr & ALIGN_MASK) != '0) || (~pwrite && (|pstrb));
    assign in_req  = (state_q == REQ) || (state_q == DRAIN);

`ifdef APB_SLV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts completed REQ/DRAIN cycles; this is the TIMEOUT_CYC-th one
    assign timeout = in_req && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && ~reg_ack;

    always_comb begin
        cnt_d = '0;
        if (in_req && ((state_d == REQ) || (state_d == DRAIN)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (setup) state_d = dec_err ? RESP : REQ;
            // A master that drops psel mid-transfer gets no response, ack or not
            REQ: begin
                if (!psel)                   state_d = (reg_ack || timeout) ? IDLE : DRAIN;
                else if (reg_ack || timeout) state_d = RESP;
            end
            DRAIN: if (reg_ack || timeout) state_d = IDLE;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == IDLE && setup) begin
            we_d    = pwrite;
            addr_d  = paddr;
            wdata_d = pwdata;
            be_d    = pwrite ? pstrb : '0;
            rdata_d = '0;
            err_d   = dec_err;
        end else if (state_q == REQ && psel) begin
            if (reg_ack) begin
                rdata_d = we_q ? '0 : reg_rdata;
                err_d   = reg_err;
            end else if (timeout) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        reg_req   = in_req;
        reg_we    = in_req & we_q;
        reg_addr  = in_req ? addr_q  : '0;
        reg_wdata = in_req ? wdata_q : '0;
        reg_be    = in_req ? be_q    : '0;
        pready    = (state_q == RESP) & psel & penable;
        pslverr   = pready & err_q;
        prdata    = (pready && !we_q) ? rdata_q : '0;
    end
endmodule

// File: tb/tb_apb_slave_bridge.sv
// Bench for apb_slave_bridge: directed cases plus random transfers against a transaction-level model.
module tb_apb_slave_bridge;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LIM = 'h400;
    localparam int TO  = 64;

    logic          pclk = 1'b0;
    logic          preset, psel, penable, pwrite;
    logic [BW-1:0] pstrb;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          reg_req, reg_we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [BW-1:0] reg_be;
    logic          reg_ack, reg_err;
    logic [DW-1:0] reg_rdata;

    int errors = 0;
    int checks = 0;

    apb_slave_bridge #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LIMIT(LIM), .TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .prdata(prdata), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .reg_err(reg_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        psel = 0; penable = 0; pwrite = 0; pstrb = '0; paddr = '0; pwdata = '0;
        reg_ack = 0; reg_err = 0; reg_rdata = '0;
    endtask

    task automatic setup_phase(input bit we, input logic [AW-1:0] addr, input logic [BW-1:0] strb,
                               input logic [DW-1:0] wd);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = we; paddr = addr; pstrb = strb; pwdata = wd;
        reg_ack = 0; reg_err = 1'($urandom); reg_rdata = DW'($urandom);
    endtask

    // One APB transfer; reg block acks 'delay' cycles after reg_req first rises.
    task automatic xfer(input bit we, input logic [AW-1:0] addr, input logic [BW-1:0] strb,
                        input logic [DW-1:0] wd, input int delay, input logic [DW-1:0] rd,
                        input bit rerr);
        bit            derr, tmo, exp_err;
        int            req_n, rdy_cyc;
        logic [DW-1:0] exp_rd;
        derr = (int'(addr) >= LIM) || (int'(addr) % BW != 0) || (!we && strb != '0);
        tmo  = 0;
`ifdef APB_SLV_TIMEOUT_EN
        tmo  = !derr && delay >= TO;
`endif
        req_n   = derr ? 0 : (tmo ? TO : delay + 1);
        rdy_cyc = req_n + 1;
        exp_err = derr || tmo || rerr;
        exp_rd  = (we || derr || tmo) ? '0 : rd;
        setup_phase(we, addr, strb, wd);
        @(negedge pclk);
        chk("t0_req", reg_req, 0);
        chk("t0_pready", pready, 0);
        for (int c = 1; c <= rdy_cyc; c++) begin
            @(posedge pclk); #1;
            penable   = 1;
            reg_ack   = (c == delay + 1) && !derr;
            reg_rdata = reg_ack ? rd : DW'($urandom);
            reg_err   = reg_ack ? rerr : 1'($urandom);
            @(negedge pclk);
            chk("reg_req", reg_req, 64'(c <= req_n));
            if (c == 1 && req_n > 0) begin
                chk("reg_we", reg_we, we);
                chk("reg_addr", reg_addr, addr);
                chk("reg_wdata", reg_wdata, wd);
                chk("reg_be", reg_be, we ? strb : '0);
            end
            chk("pready", pready, 64'(c == rdy_cyc));
            if (c == rdy_cyc) begin
                chk("pslverr", pslverr, exp_err);
                chk("prdata", prdata, exp_rd);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [BW-1:0] s;
        bit            w;
        int            sel;

        drive_idle();
        preset = 1;
        @(posedge pclk); #1;
        psel = 1; penable = 1;
        @(negedge pclk);
        chk("rst_req", reg_req, 0);
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_reg_out", {reg_we, reg_addr, reg_wdata, reg_be}, 0);
        @(posedge pclk); #1;
        drive_idle();
        preset = 0;

        xfer(1, 'h004, 'hF, 'hA5A5_1234, 0, '0, 0);
        xfer(0, 'h008, '0, '0, 2, 'hDEAD_BEEF, 0);
        xfer(0, 'h7FC, '0, '0, 0, 'h1111_1111, 0);
        xfer(0, 'h006, '0, '0, 0, 'h2222_2222, 0);
        xfer(0, 'h010, 'h1, '0, 0, 'h3333_3333, 0);
        xfer(1, 'h3FF, 'hF, 'h1, 0, '0, 0);
        xfer(1, 'h00C, 'b0101, 'h5555_AAAA, 1, '0, 1);
        xfer(1, 'h3FC, '0, 'h0BAD_F00D, 0, '0, 0);

        // Reset while in REQ abandons the transfer
        setup_phase(1, 'h020, 'hF, 'hCAFE_0001);
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        chk("mr_req_before", reg_req, 1);
        @(posedge pclk); #1;
        preset = 1;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("mr_req_after", reg_req, 0);
        chk("mr_pready", pready, 0);
        chk("mr_reg_addr", reg_addr, 0);
        @(posedge pclk); #1;
        preset = 0;
        drive_idle();

        // psel dropped in REQ; a setup during DRAIN must be ignored
        setup_phase(1, 'h040, 'hF, 'h1234_5678);
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        chk("dr_req_t1", reg_req, 1);
        @(posedge pclk); #1;
        psel = 0; penable = 0;
        @(negedge pclk);
        chk("dr_req_t2", reg_req, 1);
        chk("dr_pready_t2", pready, 0);
        @(posedge pclk); #1;
        psel = 1; penable = 0; paddr = 'h080; reg_ack = 1;
        @(negedge pclk);
        chk("dr_req_t3", reg_req, 1);
        chk("dr_pready_t3", pready, 0);
        xfer(0, 'h044, '0, '0, 1, 'h0F0F_0F0F, 0);

        // ack coincident with psel drop: back to IDLE, no response
        setup_phase(0, 'h010, '0, '0);
        @(posedge pclk); #1;
        penable = 1;
        @(posedge pclk); #1;
        psel = 0; penable = 0; reg_ack = 1; reg_rdata = 'h7777_7777;
        @(negedge pclk);
        chk("sa_req_t2", reg_req, 1);
        chk("sa_pready_t2", pready, 0);
        @(posedge pclk); #1;
        reg_ack = 0;
        @(negedge pclk);
        chk("sa_req_t3", reg_req, 0);
        chk("sa_pready_t3", pready, 0);

        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = AW'($urandom_range(LIM, (1 << AW) - 1));
            else if (sel == 1) a = AW'($urandom_range(0, LIM / BW - 1) * BW + $urandom_range(1, BW - 1));
            else               a = AW'($urandom_range(0, LIM / BW - 1) * BW);
            if (w)                               s = BW'($urandom);
            else if ($urandom_range(0, 5) == 0)  s = BW'($urandom_range(1, (1 << BW) - 1));
            else                                 s = '0;
            xfer(w, a, s, DW'($urandom), $urandom_range(0, 4), DW'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef APB_SLV_TIMEOUT_EN
        xfer(0, 'h018, '0, '0, TO - 1, 'h600D_600D, 0);
        xfer(0, 'h01C, '0, '0, 1000, 'hBAD0_BAD0, 0);
        xfer(1, 'h020, 'h3, 'h1, 1000, '0, 0);
`endif

        @(posedge pclk); #1;
        drive_idle();
        @(posedge pclk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
